cook_timer_ctrl: RTL and testbench
==================================

// Module: cook_timer_ctrl
// PURPOSE
//  Controller for the game's timing datapath: owns one shared rate divider (speed-selected
//  divisor) and sequences NUM_SLOTS grill-slot cook timers off its tick. Each slot runs
//  IDLE->COOKING->DONE->BURNT, and game logic serves/clears slots with remove.
//  Sits between the player-input/FSM layer and the VGA/score logic; clock is CLOCK_50.
// PARAMETERS
//  NUM_SLOTS  4           number of independent grill slots
//  CNT_W      28          divider counter width
//  DIV_L1     50000000    divisor for speed=01 (1 tick/s at 50 MHz)
//  DIV_L2     100000000   divisor for speed=10
//  DIV_L3     200000000   divisor for speed=11 (speed=00 is fixed divisor 1, sim/test)
//  COOK_W     6           width of cook_time and per-slot remaining counter
//  BURN_TICKS 5           ticks a slot may sit in DONE before going BURNT (>=1)
// PORTS
//  clock        in   1            system clock
//  reset_n      in   1            synchronous, active-low reset
//  enable       in   1            1 = divider and slot countdowns run; 0 = freeze
//  speed        in   2            divisor select: 00=1, 01=DIV_L1, 10=DIV_L2, 11=DIV_L3
//  start        in   NUM_SLOTS    per-slot start request (level, sampled each clock)
//  remove       in   NUM_SLOTS    per-slot serve/clear request
//  cook_time    in   COOK_W       shared cook duration in ticks, sampled on accepted start
//  tick         out  1            registered one-cycle pulse per divider period
//  slot_state   out  2*NUM_SLOTS  slot i at [2i+1:2i]: 00 IDLE,01 COOKING,10 DONE,11 BURNT
//  done_pulse   out  NUM_SLOTS    one-cycle pulse on COOKING->DONE
//  burnt_pulse  out  NUM_SLOTS    one-cycle pulse on DONE->BURNT
//  served_pulse out  NUM_SLOTS    one-cycle pulse on remove accepted in DONE
// BEHAVIOUR
//  Reset: every register cleared; all slots IDLE, remaining=0, tick=0, all pulses 0.
//  Divider: cnt counts 0..div-1 while enable=1; on cnt==div-1, cnt<=0 and tick<=1 next
//   cycle; otherwise tick<=0. div=1 -> tick high every enabled cycle. enable=0: cnt held,
//   tick<=0. speed is registered; any change of speed clears cnt to 0 (no tick that cycle).
//   Divisor comparison in CNT_W bits; cnt never exceeds div-1.
//  Slots consume the registered tick: a slot decrements on the clock edge where tick==1.
//  Per-slot FSM (priority: reset > remove > start > tick):
//   IDLE:    start=1 -> COOKING, rem<=cook_time; if cook_time==0 -> DONE, rem<=BURN_TICKS,
//            done_pulse. remove in IDLE is a no-op (start still accepted same cycle).
//   COOKING: remove -> IDLE, rem<=0. tick & rem==1 -> DONE, rem<=BURN_TICKS, done_pulse.
//            tick & rem>1 -> rem-1. start ignored.
//   DONE:    remove -> IDLE, served_pulse. tick & rem==1 -> BURNT, burnt_pulse;
//            tick & rem>1 -> rem-1. start ignored.
//   BURNT:   remove -> IDLE (no served_pulse); tick/start ignored.
//  remove and tick in same cycle: remove wins, no done/burnt pulse that cycle.
//  Slots are fully independent; simultaneous events on different slots all take effect.
//  Pulses are registered, asserted exactly one cycle, coincident with the new slot_state.
//  enable=0 freezes countdowns only; start/remove still processed.
//  reset_n low mid-cook: all slots IDLE next cycle, no pulses emitted.
// TESTING
//  speed=00, enable=1, cook_time=3, start[0] 1 cycle -> COOKING; DONE + done_pulse[0] after 3 ticks.
//  continue -> BURNT + burnt_pulse[0] exactly BURN_TICKS=5 ticks after DONE; remove -> IDLE, no served.
//  slot1 DONE, remove[1]=1 on a tick cycle with rem==1 -> IDLE + served_pulse[1], no burnt_pulse.
//  speed=01 with DIV_L1 overridden to 4: tick every 4 cycles; switch to 10 (=8) mid-count -> cnt
//   restarts, next tick 8 cycles after change.
//  enable=0 for 10 cycles while COOKING rem=2 -> rem/state unchanged, tick=0; resumes on enable=1.
//  start all slots with cook_time=0 -> all DONE + done_pulse same cycle; reset_n=0 -> all IDLE.

Source files
------------

// File: rtl/cook_timer_ctrl.sv
// Grill timing controller: one shared, speed-selectable rate divider whose registered tick
// drives NUM_SLOTS independent IDLE/COOKING/DONE/BURNT cook timers.
module cook_timer_ctrl #(
    parameter int NUM_SLOTS  = 4,
    parameter int CNT_W      = 28,
    parameter int DIV_L1     = 50000000,
    parameter int DIV_L2     = 100000000,
    parameter int DIV_L3     = 200000000,
    parameter int COOK_W     = 6,
    parameter int BURN_TICKS = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [1:0]             speed,
    input  logic [NUM_SLOTS-1:0]   start,
    input  logic [NUM_SLOTS-1:0]   remove,
    input  logic [COOK_W-1:0]      cook_time,
    output logic                   tick,
    output logic [2*NUM_SLOTS-1:0] slot_state,
    output logic [NUM_SLOTS-1:0]   done_pulse,
    output logic [NUM_SLOTS-1:0]   burnt_pulse,
    output logic [NUM_SLOTS-1:0]   served_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COOKING = 2'b01,
        ST_DONE    = 2'b10,
        ST_BURNT   = 2'b11
    } slot_state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DIV_L1_C = CNT_W'(DIV_L1);
    localparam logic [CNT_W-1:0]  DIV_L2_C = CNT_W'(DIV_L2);
    localparam logic [CNT_W-1:0]  DIV_L3_C = CNT_W'(DIV_L3);
    localparam logic [COOK_W-1:0] REM_ZERO = '0;
    localparam logic [COOK_W-1:0] REM_ONE  = COOK_W'(1);
    localparam logic [COOK_W-1:0] BURN_C   = COOK_W'(BURN_TICKS);

    // ------------------------------------------------------------------
    // Rate divider
    // ------------------------------------------------------------------
    logic [1:0]       speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_last;
    logic             tick_q, tick_d;

    always_comb begin
        case (speed_q)
            2'b01:   div_last = DIV_L1_C - CNT_ONE;
            2'b10:   div_last = DIV_L2_C - CNT_ONE;
            2'b11:   div_last = DIV_L3_C - CNT_ONE;
            default: div_last = CNT_ZERO;
        endcase
    end

    // A speed change restarts the period from zero so the new rate applies cleanly.
    always_comb begin
        speed_d = speed;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (speed != speed_q) begin
            cnt_d = CNT_ZERO;
        end else if (enable) begin
            if (cnt_q >= div_last) begin
                cnt_d  = CNT_ZERO;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            speed_q <= 2'b00;
            cnt_q   <= CNT_ZERO;
            tick_q  <= 1'b0;
        end else begin
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    // Countdowns stay frozen while disabled, even on the cycle a stale tick is still high.
    logic slot_tick;
    assign slot_tick = tick_q & enable;

    // ------------------------------------------------------------------
    // Per-slot cook timers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        slot_state_t       st_q, st_d;
        logic [COOK_W-1:0] rem_q, rem_d;
        logic              done_q, done_d;
        logic              burnt_q, burnt_d;
        logic              served_q, served_d;

        always_comb begin
            st_d     = st_q;
            rem_d    = rem_q;
            done_d   = 1'b0;
            burnt_d  = 1'b0;
            served_d = 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (start[gi]) begin
                        if (cook_time == REM_ZERO) begin
                            st_d   = ST_DONE;
                            rem_d  = BURN_C;
                            done_d = 1'b1;
                        end else begin
                            st_d  = ST_COOKING;
                            rem_d = cook_time;
                        end
                    end
                end
                ST_COOKING: begin
                    if (remove[gi]) begin
                        st_d  = ST_IDLE;
                        rem_d = REM_ZERO;
                    end else if (slot_tick) begin
                        if (rem_q <= REM_ONE) begin
                            st_d   = ST_DONE;
                            rem_d  = BURN_C;
                            done_d = 1'b1;
                        end else begin
                            rem_d = rem_q - REM_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Serving beats burning when both land on the same edge.
                    if (remove[gi]) begin
                        st_d     = ST_IDLE;
                        rem_d    = REM_ZERO;
                        served_d = 1'b1;
                    end else if (slot_tick) begin
                        if (rem_q <= REM_ONE) begin
                            st_d    = ST_BURNT;
                            rem_d   = REM_ZERO;
                            burnt_d = 1'b1;
                        end else begin
                            rem_d = rem_q - REM_ONE;
                        end
                    end
                end
                ST_BURNT: begin
                    if (remove[gi]) begin
                        st_d  = ST_IDLE;
                        rem_d = REM_ZERO;
                    end
                end
                default: begin
                    st_d  = ST_IDLE;
                    rem_d = REM_ZERO;
                end
            endcase
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                st_q     <= ST_IDLE;
                rem_q    <= REM_ZERO;
                done_q   <= 1'b0;
                burnt_q  <= 1'b0;
                served_q <= 1'b0;
            end else begin
                st_q     <= st_d;
                rem_q    <= rem_d;
                done_q   <= done_d;
                burnt_q  <= burnt_d;
                served_q <= served_d;
            end
        end

        assign slot_state[2*gi +: 2] = st_q;
        assign done_pulse[gi]        = done_q;
        assign burnt_pulse[gi]       = burnt_q;
        assign served_pulse[gi]      = served_q;
    end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Bench for cook_timer_ctrl: directed scenarios with literal expectations plus a random run,
// all cycle-checked against an abstract tick/slot model.
module tb_cook_timer_ctrl;

    localparam int NS = 4;
    localparam int CW = 6;
    localparam int BT = 5;
    localparam int L1 = 4;
    localparam int L2 = 8;
    localparam int L3 = 16;

    localparam int IDLE    = 0;
    localparam int COOKING = 1;
    localparam int DONE    = 2;
    localparam int BURNT   = 3;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [1:0]      speed;
    logic [NS-1:0]   start;
    logic [NS-1:0]   remove;
    logic [CW-1:0]   cook_time;
    logic            tick;
    logic [2*NS-1:0] slot_state;
    logic [NS-1:0]   done_pulse;
    logic [NS-1:0]   burnt_pulse;
    logic [NS-1:0]   served_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cook_timer_ctrl #(
        .NUM_SLOTS (NS),
        .CNT_W     (28),
        .DIV_L1    (L1),
        .DIV_L2    (L2),
        .DIV_L3    (L3),
        .COOK_W    (CW),
        .BURN_TICKS(BT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .speed       (speed),
        .start       (start),
        .remove      (remove),
        .cook_time   (cook_time),
        .tick        (tick),
        .slot_state  (slot_state),
        .done_pulse  (done_pulse),
        .burnt_pulse (burnt_pulse),
        .served_pulse(served_pulse)
    );

    // ---------------- behavioural model ----------------
    int m_state[NS];
    int m_left[NS];
    bit m_done[NS];
    bit m_burnt[NS];
    bit m_served[NS];
    int m_speed;
    int m_phase;
    bit m_tick;

    function automatic int divisor(int s);
        case (s)
            1:       return L1;
            2:       return L2;
            3:       return L3;
            default: return 1;
        endcase
    endfunction

    always @(posedge clock) begin : model_upd
        bit tk;
        tk = m_tick && (enable == 1'b1);
        if (reset_n !== 1'b1) begin
            m_speed = 0;
            m_phase = 0;
            m_tick  = 0;
            for (int i = 0; i < NS; i++) begin
                m_state[i] = IDLE; m_left[i] = 0;
                m_done[i] = 0; m_burnt[i] = 0; m_served[i] = 0;
            end
        end else begin
            if (int'(speed) != m_speed) begin
                m_speed = int'(speed);
                m_phase = 0;
                m_tick  = 0;
            end else if (enable) begin
                m_phase = m_phase + 1;
                m_tick  = (m_phase == divisor(m_speed));
                if (m_tick) m_phase = 0;
            end else begin
                m_tick = 0;
            end
            for (int i = 0; i < NS; i++) begin
                m_done[i] = 0; m_burnt[i] = 0; m_served[i] = 0;
                if (remove[i] && m_state[i] != IDLE) begin
                    if (m_state[i] == DONE) m_served[i] = 1;
                    m_state[i] = IDLE;
                    m_left[i]  = 0;
                end else if (m_state[i] == IDLE && start[i]) begin
                    if (int'(cook_time) == 0) begin
                        m_state[i] = DONE; m_left[i] = BT; m_done[i] = 1;
                    end else begin
                        m_state[i] = COOKING; m_left[i] = int'(cook_time);
                    end
                end else if (tk && (m_state[i] == COOKING || m_state[i] == DONE)) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        if (m_state[i] == COOKING) begin
                            m_state[i] = DONE; m_left[i] = BT; m_done[i] = 1;
                        end else begin
                            m_state[i] = BURNT; m_burnt[i] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clock) begin : compare
        logic [2*NS-1:0] es;
        logic [NS-1:0]   ed, eb, esv;
        #1;
        for (int i = 0; i < NS; i++) begin
            es[2*i +: 2] = 2'(m_state[i]);
            ed[i]  = m_done[i];
            eb[i]  = m_burnt[i];
            esv[i] = m_served[i];
        end
        expect_eq("model_tick",   {31'd0, tick}, {31'd0, m_tick});
        expect_eq("model_state",  32'(slot_state), 32'(es));
        expect_eq("model_done",   32'(done_pulse), 32'(ed));
        expect_eq("model_burnt",  32'(burnt_pulse), 32'(eb));
        expect_eq("model_served", 32'(served_pulse), 32'(esv));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (tick !== 1'b1 && n < max);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset_n = 1'b0; enable = 1'b0; speed = 2'b00;
        start = '0; remove = '0; cook_time = '0;
        step(2);
        expect_eq("reset_state", 32'(slot_state), 32'h0);
        expect_eq("reset_tick", {31'd0, tick}, 32'h0);
        expect_eq("reset_pulses", 32'({done_pulse, burnt_pulse, served_pulse}), 32'h0);

        // Slot 0: cook 3 ticks, burn after 5 more, clear without serving.
        reset_n = 1'b1; enable = 1'b1;
        step(2);
        cook_time = 6'd3; start = 4'b0001;
        step(1);
        start = '0;
        expect_eq("s0_cooking", 32'(slot_state[1:0]), 32'h1);
        step(2);
        expect_eq("s0_still_cooking", 32'(slot_state[1:0]), 32'h1);
        step(1);
        expect_eq("s0_done", 32'(slot_state[1:0]), 32'h2);
        expect_eq("s0_done_pulse", 32'(done_pulse), 32'h1);
        step(4);
        expect_eq("s0_still_done", 32'(slot_state[1:0]), 32'h2);
        step(1);
        expect_eq("s0_burnt", 32'(slot_state[1:0]), 32'h3);
        expect_eq("s0_burnt_pulse", 32'(burnt_pulse), 32'h1);
        remove = 4'b0001;
        step(1);
        remove = '0;
        expect_eq("s0_cleared", 32'(slot_state[1:0]), 32'h0);
        expect_eq("s0_no_served", 32'(served_pulse), 32'h0);

        // Slot 1: serve on the same edge it would burn.
        cook_time = 6'd1; start = 4'b0010;
        step(1);
        start = '0;
        step(1);
        expect_eq("s1_done", 32'(slot_state[3:2]), 32'h2);
        step(4);
        remove = 4'b0010;
        step(1);
        remove = '0;
        expect_eq("s1_idle", 32'(slot_state[3:2]), 32'h0);
        expect_eq("s1_served", 32'(served_pulse), 32'h2);
        expect_eq("s1_no_burnt", 32'(burnt_pulse), 32'h0);

        // Slot 2: freeze with rem=2 for 10 cycles.
        cook_time = 6'd4; start = 4'b0100;
        step(1);
        start = '0;
        step(2);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            expect_eq("freeze_tick", {31'd0, tick}, 32'h0);
            expect_eq("freeze_state", 32'(slot_state[5:4]), 32'h1);
        end
        enable = 1'b1;
        step(2);
        expect_eq("resume_cooking", 32'(slot_state[5:4]), 32'h1);
        step(1);
        expect_eq("resume_done", 32'(slot_state[5:4]), 32'h2);
        expect_eq("resume_done_pulse", 32'(done_pulse), 32'h4);
        remove = 4'b0100;
        step(1);
        remove = '0;

        // Divider periods and mid-count speed change.
        speed = 2'b01;
        step(1);
        wait_tick(50, n);
        expect_eq("div4_first", 32'(n), 32'd4);
        wait_tick(50, n);
        expect_eq("div4_period", 32'(n), 32'd4);
        step(2);
        speed = 2'b10;
        step(1);
        expect_eq("speed_change_no_tick", {31'd0, tick}, 32'h0);
        wait_tick(50, n);
        expect_eq("div8_after_change", 32'(n), 32'd8);
        wait_tick(50, n);
        expect_eq("div8_period", 32'(n), 32'd8);
        speed = 2'b00;
        step(1);

        // All slots with zero cook time, then reset.
        cook_time = 6'd0; start = 4'b1111;
        step(1);
        start = '0;
        expect_eq("all_done", 32'(slot_state), 32'hAA);
        expect_eq("all_done_pulse", 32'(done_pulse), 32'hF);
        reset_n = 1'b0;
        step(1);
        expect_eq("reset_mid_state", 32'(slot_state), 32'h0);
        expect_eq("reset_mid_pulses", 32'({done_pulse, burnt_pulse, served_pulse}), 32'h0);
        reset_n = 1'b1;

        // Randomised traffic, checked cycle-by-cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            reset_n   = ($urandom_range(0, 499) != 0);
            cook_time = CW'($urandom_range(0, 7));
            for (int i = 0; i < NS; i++) begin
                start[i]  = ($urandom_range(0, 7) == 0);
                remove[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
            else if (speed != 2'b00 && $urandom_range(0, 29) == 0) speed = 2'b00;
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
